alu_issue_seq: RTL and testbench
================================

# alu_issue_seq

Command sequencer placed in front of the 4-bit combinational ALU (`op`: 00 = arithmetic shift right by `inC`, 01 = logical shift right by `inC`, 10 = A−B, 11 = A+B). It accepts register-based commands over a valid/ready channel and keeps a 4-entry × 4-bit register file. For each command it drives the ALU operand inputs from registers, captures the ALU result into the register file, and presents the result on a valid/ready output channel. One command is in flight at a time.

## Interface
Parameters:
- `NREG`, 4: register-file depth; fixed at 4 because index fields are 2 bits wide.
- `DW`, 4: datapath width; must match the ALU.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_cmd` is valid.
- `in_ready` output 1: the block can accept a command.
- `in_cmd` input 11: command word.
  - `[10]` kind: 1 = LOAD, 0 = ALU.
  - `[9:8]` rd.
  - `[7:6]` rs.
  - `[5:4]` rt.
  - `[3:2]` op.
  - `[1:0]` shamt.
  - For LOAD, `[3:0]` is imm.
- `alu_a` output 4: drives ALU `inA`.
- `alu_b` output 4: drives ALU `inB`.
- `alu_c` output 2: drives ALU `inC`.
- `alu_op` output 2: drives ALU `op`.
- `alu_ans` input 4: ALU `ans`.
- `out_valid` output 1: `out_data` holds a result.
- `out_ready` input 1: the consumer takes the result.
- `out_data` output 4: ALU result of the last ALU command.
- `dbg_sel` input 2: register-file read index.
- `dbg_data` output 4: combinational read, `rf[dbg_sel]`.

## Operation
- **States:** IDLE, EXEC, OUT. Reset state is IDLE.
- `in_ready` = (state == IDLE). It is combinational from state.

**IDLE, accept on `in_valid && in_ready`:**
- **LOAD:** `rf[rd]` ← imm at that edge. State stays IDLE. No output is produced.
- **ALU:** at that edge, register the ALU drive signals: `alu_a` ← `rf[rs]`, `alu_b` ← `rf[rt]`, `alu_c` ← shamt, `alu_op` ← op. Latch rd internally. Go to EXEC.

**EXEC:**
- `alu_*` are held stable from registers.
- At the next edge: `rf[rd]` ← `alu_ans`, `out_data` ← `alu_ans`, `out_valid` ← 1. Go to OUT.

**OUT:**
- `out_valid` = 1; `out_data` and `alu_*` are held.
- On `out_valid && out_ready`: `out_valid` ← 0 at that edge and state → IDLE.
- Otherwise stay in OUT indefinitely.

**Data rules:**
- Arithmetic is 4-bit and wraps modulo 16. The block does no arithmetic itself; all results come from `alu_ans`.
- rs == rt and rd == rs/rt are legal. Operands are read before the write-back, and commands serialize, so the next command sees the updated register.
- `in_valid` while `in_ready` = 0: the command is not consumed. The producer must hold it.
- `dbg_data` reflects register-file writes the cycle after the writing edge.

**Reset (`rst_n` low, asynchronous, any state):**
- state → IDLE.
- All `rf` entries, `alu_a`, `alu_b`, `alu_c`, `alu_op`, `out_data` → 0.
- `out_valid` → 0.
- Commands presented while `rst_n` is low are ignored.
- A command in EXEC or OUT is discarded and its write-back does not occur.

## Timing
- **Reset values:**
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_data`, `alu_a`, `alu_b`, `alu_c`, `alu_op` = 0.
  - `dbg_data` = 0.
- **LOAD:** 1 cycle; the next command can be accepted at the following edge.
- **ALU command latency:** accepted at edge N, `alu_*` valid after N, `out_valid` = 1 after edge N+1. The earliest handshake is edge N+2.
- **Throughput:** one ALU command per 3 cycles when `out_ready` is held high.
- **`alu_ans`:** sampled only at the EXEC→OUT edge. It may change freely at other times.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run, then release.
  - `in_ready` = 1, `out_valid` = 0.
  - All `alu_*` and `out_data` = 0.
  - `dbg_data` = 0 for every `dbg_sel`.
- **ADD:** LOAD r1 = 0xA, LOAD r2 = 0x3, then ALU op = 11, rd = 3, rs = 1, rt = 2.
  - `alu_a` = 0xA, `alu_b` = 0x3, `alu_op` = 11.
  - `out_data` = 0xD with `out_valid` after edge N+1.
  - `rf[3]` = 0xD.
- **Shifts,** with r1 = 0xA:
  - op = 00, shamt = 2, rd = 0: result 0xE.
  - op = 01, shamt = 2: result 0x2.
  - `alu_c` = 2 during EXEC.
- **Wrap and self-dependency:**
  - SUB, rd = 0, rs = 2 (0x3), rt = 1 (0xA): result 0x9.
  - Then ADD, rd = 1, rs = 1, rt = 1 with r1 = 0xA: result 0x4, and `rf[1]` = 0x4.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles in OUT with a second command presented.
  - `out_valid` = 1 and `out_data` stable throughout.
  - `in_ready` = 0; the second command is not accepted.
  - Raise `out_ready`: handshake completes, and the second command is accepted one edge later.
- **Reset mid-EXEC:** pull `rst_n` low while in EXEC on ADD rd = 3.
  - Immediately: `out_valid` = 0, state IDLE, `rf[3]` = 0.
  - No result appears after release.

Source files
------------

// File: rtl/alu_issue_seq.sv
// Command sequencer in front of a 4-bit combinational ALU: loads immediates into a
// small register file, issues ALU ops one at a time and returns results over valid/ready.
module alu_issue_seq #(
   parameter int NREG = 4,
   parameter int DW   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [10:0]   in_cmd,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [1:0]    alu_c,
   output logic [1:0]    alu_op,
   input  logic [DW-1:0] alu_ans,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   input  logic [1:0]    dbg_sel,
   output logic [DW-1:0] dbg_data
);

   typedef struct packed {
      logic       kind;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [1:0] rt;
      logic [1:0] op;
      logic [1:0] shamt;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

   state_t                   state;
   cmd_t                     cmd;
   logic [NREG-1:0][DW-1:0]  rf;
   logic [1:0]               rd_q;

   assign cmd      = cmd_t'(in_cmd);
   assign in_ready = (state == IDLE);
   assign dbg_data = rf[dbg_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rf        <= '0;
         rd_q      <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_c     <= '0;
         alu_op    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (cmd.kind) begin
                     // LOAD immediate occupies the low nibble of the command word
                     rf[cmd.rd] <= in_cmd[DW-1:0];
                  end else begin
                     alu_a  <= rf[cmd.rs];
                     alu_b  <= rf[cmd.rt];
                     alu_c  <= cmd.shamt;
                     alu_op <= cmd.op;
                     rd_q   <= cmd.rd;
                     state  <= EXEC;
                  end
               end
            end
            EXEC: begin
               rf[rd_q]  <= alu_ans;
               out_data  <= alu_ans;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Randomized self-checking bench for alu_issue_seq with a behavioural ALU and
// a register-file reference model.
module tb_alu_issue_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_cmd;
   logic [3:0]  alu_a, alu_b, alu_ans, out_data, dbg_data;
   logic [1:0]  alu_c, alu_op, dbg_sel;
   logic        out_valid, out_ready;

   int n_chk  = 0;
   int n_pass = 0;
   logic [3:0] ref_rf [4];

   alu_issue_seq #(.NREG(4), .DW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_cmd(in_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
      .alu_op(alu_op), .alu_ans(alu_ans), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .dbg_sel(dbg_sel),
      .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] alu_f(input logic [3:0] a, b,
                                        input logic [1:0] c, op);
      logic [3:0] r;
      case (op)
         2'b00:   r = 4'($signed(a) >>> c);
         2'b01:   r = a >> c;
         2'b10:   r = a - b;
         default: r = a + b;
      endcase
      return r;
   endfunction

   // the external combinational ALU
   assign alu_ans = alu_f(alu_a, alu_b, alu_c, alu_op);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic chk_rf(input string tag, input logic [1:0] idx);
      dbg_sel = idx;
      #1;
      chk(tag, dbg_data, ref_rf[idx]);
   endtask

   task automatic chk_reset_state();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_c", alu_c, 0);
      chk("rst_alu_op", alu_op, 0);
      chk("rst_out_data", out_data, 0);
      for (int i = 0; i < 4; i++) begin
         ref_rf[i] = 4'h0;
         chk_rf("rst_rf", 2'(i));
      end
   endtask

   task automatic load(input logic [1:0] rd, input logic [3:0] imm);
      chk("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_cmd   = {1'b1, rd, 4'h0, imm};
      @(posedge clk); #1;
      in_valid = 1'b0;
      ref_rf[rd] = imm;
      chk("load_in_ready_after", in_ready, 1);
      chk_rf("load_rf", rd);
   endtask

   task automatic alu_cmd(input logic [1:0] rd, rs, rt, op, sh, input int hold,
                          input bit pend = 0, input logic [1:0] prd = 2'd0,
                          input logic [3:0] pimm = 4'h0);
      logic [3:0] a, b, exp;
      a   = ref_rf[rs];
      b   = ref_rf[rt];
      exp = alu_f(a, b, sh, op);
      chk("alu_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_cmd   = {1'b0, rd, rs, rt, op, sh};
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("exec_alu_a", alu_a, a);
      chk("exec_alu_b", alu_b, b);
      chk("exec_alu_c", alu_c, sh);
      chk("exec_alu_op", alu_op, op);
      chk("exec_out_valid", out_valid, 0);
      chk("exec_in_ready", in_ready, 0);
      @(posedge clk); #1;
      ref_rf[rd] = exp;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp);
      if (pend) begin
         in_valid = 1'b1;
         in_cmd   = {1'b1, prd, 4'h0, pimm};
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", out_valid, 1);
         chk("hold_out_data", out_data, exp);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_alu_a", alu_a, a);
         if (pend) chk_rf("hold_no_accept", prd);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hs_out_valid", out_valid, 0);
      chk("hs_in_ready", in_ready, 1);
      chk_rf("wb_rf", rd);
      if (pend) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         ref_rf[prd] = pimm;
         chk_rf("pend_accepted", prd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b1; in_cmd = {1'b1, 2'd1, 4'h0, 4'hF};
      out_ready = 1'b0; dbg_sel = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk_reset_state();
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed: ADD, shifts, wrap, self-dependency
      load(2'd1, 4'hA);
      load(2'd2, 4'h3);
      alu_cmd(2'd3, 2'd1, 2'd2, 2'b11, 2'd0, 0);
      alu_cmd(2'd0, 2'd1, 2'd1, 2'b00, 2'd2, 1);
      alu_cmd(2'd0, 2'd1, 2'd1, 2'b01, 2'd2, 0);
      alu_cmd(2'd0, 2'd2, 2'd1, 2'b10, 2'd0, 0);
      alu_cmd(2'd1, 2'd1, 2'd1, 2'b11, 2'd0, 0);
      // backpressure with a pending LOAD to r2
      alu_cmd(2'd3, 2'd2, 2'd2, 2'b11, 2'd0, 5, 1'b1, 2'd2, 4'h7);

      // mid-run reset, then reset mid-EXEC
      rst_n = 1'b0; #1;
      chk_reset_state();
      rst_n = 1'b1;
      @(posedge clk); #1;
      load(2'd1, 4'h5);
      load(2'd2, 4'h6);
      in_valid = 1'b1;
      in_cmd   = {1'b0, 2'd3, 2'd1, 2'd2, 2'b11, 2'd0};
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mid_exec_in_ready", in_ready, 0);
      rst_n = 1'b0; #1;
      chk_reset_state();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_no_out", out_valid, 0);
         chk_rf("post_rst_rf3", 2'd3);
      end

      // randomized commands against the reference model
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0)
            load(2'($urandom), 4'($urandom));
         else
            alu_cmd(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                    2'($urandom), int'($urandom_range(0, 2)));
      end
      for (int i = 0; i < 4; i++) chk_rf("final_rf", 2'(i));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
